// File: rtl/cpu_if_pkg.sv
// Shared types for the core-side store buffer: size codes, downstream FSM states
// and the buffered store entry layout.
package cpu_if_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef logic [2:0] dstate_t;

   localparam dstate_t D_IDLE  = 3'd0;
   localparam dstate_t D_WADDR = 3'd1;
   localparam dstate_t D_WDATA = 3'd2;
   localparam dstate_t D_RADDR = 3'd3;
   localparam dstate_t D_RDATA = 3'd4;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic        uncached;
   } wb_entry_t;

endpackage

// File: rtl/data_write_buffer_if.sv
// SRAM-like request/acknowledge bus used on both the core side and the adapter side.
interface data_write_buffer_if;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        uncached;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata, uncached,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata, uncached,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/wb_fifo.sv
// Store-entry FIFO; the head entry is read straight from the storage array so the
// downstream port always sees registered fields.
module wb_fifo
   import cpu_if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  wb_entry_t                din,
   output wb_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   wb_entry_t       mem_reg [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic            push_en;
   logic            pop_en;

   assign full    = (count_reg == DEPTH_C);
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (push_en)
         mem_reg[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_en)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/data_write_buffer.sv
// Store buffer between the core data port and the cache adapter: stores are acked
// after one cycle and drained in order; loads pass only when the buffer is empty.
module data_write_buffer
   import cpu_if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   data_write_buffer_if.slave   cpu,
   data_write_buffer_if.master  mem,
   output logic                 buf_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE_C = 1;

   dstate_t      state_reg;
   dstate_t      state_next;
   wb_entry_t    head;
   wb_entry_t    din;
   logic         full;
   logic         empty;
   logic [AW:0]  count;
   logic [31:0]  ld_addr_reg;
   logic [1:0]   ld_size_reg;
   logic         ld_uncached_reg;
   logic         wack_reg;
   logic         rd_busy;
   logic         st_accept;
   logic         ld_accept;
   logic         pop;

   assign rd_busy   = (state_reg == D_RADDR) || (state_reg == D_RDATA);
   // Nothing is accepted while reset is held, even though the FIFO already reads empty.
   assign st_accept = ~rst & cpu.req & cpu.wr & ~full & ~rd_busy;
   assign ld_accept = ~rst & cpu.req & ~cpu.wr & (count == '0) & (state_reg == D_IDLE);
   assign pop       = (state_reg == D_WDATA) & mem.data_ok;

   assign din = '{addr: cpu.addr, size: cpu.size, wdata: cpu.wdata, uncached: cpu.uncached};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (st_accept),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         // A store pushed this cycle is presented downstream on the very next cycle.
         D_IDLE: begin
            if (!empty || st_accept)
               state_next = D_WADDR;
            else if (ld_accept)
               state_next = D_RADDR;
         end
         D_WADDR: if (mem.addr_ok) state_next = D_WADDR + 3'd1;
         D_WDATA: begin
            if (mem.data_ok)
               state_next = ((count != ONE_C) || st_accept) ? D_WADDR : D_IDLE;
         end
         D_RADDR: if (mem.addr_ok) state_next = D_RDATA;
         D_RDATA: if (mem.data_ok) state_next = D_IDLE;
         default: state_next = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= D_IDLE;
         wack_reg        <= 1'b0;
         ld_addr_reg     <= '0;
         ld_size_reg     <= '0;
         ld_uncached_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         wack_reg  <= st_accept;
         if (ld_accept) begin
            ld_addr_reg     <= cpu.addr;
            ld_size_reg     <= cpu.size;
            ld_uncached_reg <= cpu.uncached;
         end
      end
   end

   assign cpu.addr_ok = st_accept | ld_accept;
   assign cpu.data_ok = wack_reg | ((state_reg == D_RDATA) & mem.data_ok);
   assign cpu.rdata   = mem.rdata;

   assign mem.req      = (state_reg == D_WADDR) || (state_reg == D_RADDR);
   assign mem.wr       = ~rd_busy;
   assign mem.size     = rd_busy ? ld_size_reg     : head.size;
   assign mem.addr     = rd_busy ? ld_addr_reg     : head.addr;
   assign mem.uncached = rd_busy ? ld_uncached_reg : head.uncached;
   assign mem.wdata    = head.wdata;

   assign buf_empty = empty & (state_reg == D_IDLE);

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed and random stimulus for data_write_buffer, checked each cycle against a
// transaction-level model (outstanding stores, load in flight, adapter behaviour).
module tb_data_write_buffer;
   import cpu_if_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic buf_empty;

   data_write_buffer_if cpu_bus();
   data_write_buffer_if mem_bus();

   data_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (cpu_bus),
      .mem       (mem_bus),
      .buf_empty (buf_empty)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   wb_entry_t   exp_q[$];
   int          outst;
   bit          ld_inflight;
   bit          ack_next;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        ld_unc;
   bit          ad_busy;
   bit          ad_is_rd;
   int          ad_cnt;
   logic [31:0] ad_rd_val;
   bit          ad_hold;
   int          ad_stall;
   int          ad_lat;
   bit          force_rd;
   logic [31:0] force_rd_val;
   bit          last_aok;
   int          st_accepts;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic reset_model();
      exp_q.delete();
      outst       = 0;
      ld_inflight = 0;
      ack_next    = 0;
      ad_busy     = 0;
      ad_cnt      = 0;
   endtask

   task automatic drive(bit req, bit wr, logic [1:0] sz, logic [31:0] a, logic [31:0] d, bit unc);
      cpu_bus.req      = req;
      cpu_bus.wr       = wr;
      cpu_bus.size     = sz;
      cpu_bus.addr     = a;
      cpu_bus.wdata    = d;
      cpu_bus.uncached = unc;
   endtask

   // One clock cycle: adapter response, checks against the model, model update.
   task automatic tick();
      bit        exp_aok, exp_dok, exp_req, rd_done, st_acc, ld_acc, aok_hs;
      wb_entry_t e;
      @(negedge clk);
      mem_bus.addr_ok = 1'b0;
      mem_bus.data_ok = 1'b0;
      mem_bus.rdata   = $urandom;
      if (ad_busy) begin
         if (ad_cnt == 0) begin
            mem_bus.data_ok = 1'b1;
            if (ad_is_rd) mem_bus.rdata = ad_rd_val;
         end
      end else begin
         if (!ad_hold && $urandom_range(99) >= ad_stall) mem_bus.addr_ok = 1'b1;
         if ($urandom_range(3) == 0) mem_bus.data_ok = 1'b1;  // stray pulse, must be ignored
      end
      #1;
      if (ld_inflight)     exp_aok = 0;
      else if (cpu_bus.wr) exp_aok = cpu_bus.req && (outst < DEPTH);
      else                 exp_aok = cpu_bus.req && (outst == 0);
      rd_done = ad_busy && (ad_cnt == 0) && ad_is_rd;
      exp_dok = ack_next || rd_done;
      exp_req = (outst > 0 || ld_inflight) && !ad_busy;
      chk("cpu_addr_ok", cpu_bus.addr_ok, exp_aok);
      chk("cpu_data_ok", cpu_bus.data_ok, exp_dok);
      chk("mem_req", mem_bus.req, exp_req);
      chk("buf_empty", buf_empty, (outst == 0 && !ld_inflight));
      if (rd_done) chk("cpu_rdata", cpu_bus.rdata, ad_rd_val);
      aok_hs = exp_req && mem_bus.addr_ok;
      if (aok_hs) begin
         if (outst > 0) begin
            e = exp_q[0];
            chk("mem_wr", mem_bus.wr, 1);
            chk("mem_addr", mem_bus.addr, e.addr);
            chk("mem_size", mem_bus.size, e.size);
            chk("mem_wdata", mem_bus.wdata, e.wdata);
            chk("mem_uncached", mem_bus.uncached, e.uncached);
            $display("drain  addr=%h size=%0d wdata=%h unc=%0d", mem_bus.addr, mem_bus.size,
                     mem_bus.wdata, mem_bus.uncached);
         end else begin
            chk("mem_rd_wr", mem_bus.wr, 0);
            chk("mem_rd_addr", mem_bus.addr, ld_addr);
            chk("mem_rd_size", mem_bus.size, ld_size);
            chk("mem_rd_uncached", mem_bus.uncached, ld_unc);
         end
      end
      last_aok = cpu_bus.addr_ok;
      st_acc = exp_aok && cpu_bus.wr;
      ld_acc = exp_aok && !cpu_bus.wr;
      if (ad_busy) begin
         if (ad_cnt == 0) begin
            ad_busy = 0;
            if (ad_is_rd) ld_inflight = 0;
            else begin
               outst--;
               void'(exp_q.pop_front());
            end
         end else begin
            ad_cnt--;
         end
      end else if (aok_hs) begin
         ad_busy   = 1;
         ad_is_rd  = (outst == 0);
         ad_cnt    = (ad_lat < 0) ? int'($urandom_range(3)) : ad_lat;
         ad_rd_val = force_rd ? force_rd_val : $urandom;
      end
      if (st_acc) begin
         exp_q.push_back('{addr: cpu_bus.addr, size: cpu_bus.size, wdata: cpu_bus.wdata,
                           uncached: cpu_bus.uncached});
         outst++;
         st_accepts++;
         $display("store  addr=%h size=%0d wdata=%h unc=%0d", cpu_bus.addr, cpu_bus.size,
                  cpu_bus.wdata, cpu_bus.uncached);
      end
      if (ld_acc) begin
         ld_inflight = 1;
         ld_addr     = cpu_bus.addr;
         ld_size     = cpu_bus.size;
         ld_unc      = cpu_bus.uncached;
         $display("load   addr=%h size=%0d unc=%0d", cpu_bus.addr, cpu_bus.size, cpu_bus.uncached);
      end
      if (rd_done) $display("loaddata rdata=%h", cpu_bus.rdata);
      ack_next = st_acc;
      @(posedge clk);
      #1;
   endtask

   task automatic hold_until_accept(string tag, int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!last_aok && n < budget);
      chk({tag, "_accept"}, last_aok, 1);
      cpu_bus.req = 1'b0;
   endtask

   task automatic drain(int budget);
      int n = 0;
      cpu_bus.req = 1'b0;
      while ((outst != 0 || ld_inflight) && n < budget) begin
         tick();
         n++;
      end
      tick();
      chk("drain_empty", buf_empty, 1);
   endtask

   initial begin
      rst = 1'b1;
      mem_bus.addr_ok = 1'b0;
      mem_bus.data_ok = 1'b0;
      mem_bus.rdata   = '0;
      drive(1, 1, SIZE_WORD, 32'h0000_0040, 32'h1, 0);
      reset_model();
      ad_hold = 0; ad_stall = 0; ad_lat = 0; force_rd = 0; force_rd_val = '0; st_accepts = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr_ok", cpu_bus.addr_ok, 0);
      chk("rst_data_ok", cpu_bus.data_ok, 0);
      chk("rst_mem_req", mem_bus.req, 0);
      chk("rst_buf_empty", buf_empty, 1);
      cpu_bus.req = 1'b0;
      #1 rst = 1'b0;

      // Single uncached word store, drained right away.
      drive(1, 1, SIZE_WORD, 32'hBFAF_8000, 32'h1234_5678, 1);
      tick();
      cpu_bus.req = 1'b0;
      drain(20);

      // Five back-to-back stores with the adapter refusing addresses.
      ad_hold = 1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, SIZE_WORD, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 0);
         hold_until_accept("fill", 3);
      end
      drive(1, 1, SIZE_WORD, 32'h1010, 32'hA004, 0);
      repeat (3) tick();
      ad_hold = 0;
      hold_until_accept("fifth", 20);
      drain(40);

      // Store then load to the same address: load waits for the store to complete.
      ad_lat = 2; force_rd = 1; force_rd_val = 32'hCAFE_0001;
      drive(1, 1, SIZE_WORD, 32'h0000_0100, 32'h5555_AAAA, 0);
      tick();
      drive(1, 0, SIZE_WORD, 32'h0000_0100, 32'h0, 0);
      hold_until_accept("raw_load", 20);
      drain(20);
      force_rd = 0;

      // Store requested while a slow load is in flight.
      ad_lat = 4;
      drive(1, 0, SIZE_HALF, 32'h0000_0202, 32'h0, 1);
      hold_until_accept("slow_load", 10);
      drive(1, 1, SIZE_BYTE, 32'h0000_0303, 32'h0000_00EE, 0);
      hold_until_accept("store_after_load", 30);
      drain(30);

      // Asynchronous reset in the middle of a write data phase with 3 stores queued.
      ad_hold = 1; ad_lat = 10;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, SIZE_WORD, 32'h2000 + 32'(i * 4), 32'hB000 + 32'(i), 0);
         tick();
      end
      cpu_bus.req = 1'b0;
      ad_hold = 0;
      for (int n = 0; n < 10 && !(ad_busy && !ad_is_rd); n++) tick();
      tick();
      drive(1, 0, SIZE_WORD, 32'h0000_0400, 32'h0, 0);
      #1 rst = 1'b1;
      mem_bus.addr_ok = 1'b0;
      mem_bus.data_ok = 1'b0;
      #1;
      chk("arst_mem_req", mem_bus.req, 0);
      chk("arst_data_ok", cpu_bus.data_ok, 0);
      chk("arst_buf_empty", buf_empty, 1);
      chk("arst_addr_ok", cpu_bus.addr_ok, 0);
      cpu_bus.req = 1'b0;
      reset_model();
      @(posedge clk);
      #2 rst = 1'b0;
      ad_lat = 0;
      drive(1, 1, SIZE_WORD, 32'h0000_0500, 32'hD00D_F00D, 0);
      tick();
      drain(20);

      // Random mixed traffic with a stalling adapter; exercises pointer wrap.
      ad_lat = -1; ad_stall = 40;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) != 0)
            drive(1, 1'($urandom_range(99) < 80), 2'($urandom_range(2)), $urandom, $urandom,
                  1'($urandom_range(1)));
         else
            cpu_bus.req = 1'b0;
         tick();
      end
      drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_write_buffer.md
Name: data_write_buffer

Overview:
Store buffer placed between the mips core data port and the data port of cpu_axi_adapter_system_cache, inside the CPU top.
- Accepts stores on the SRAM-like request interface and acknowledges them after one cycle, without waiting for memory.
- Drains buffered stores to the adapter strictly in order, one downstream transaction at a time.
- Passes loads through only once the buffer is empty, so load/store ordering is preserved with no address compare.

Parameters:
DEPTH, 4, number of store entries; must be a power of two, 2 or greater.

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
cpu_req  in  1  core request valid
cpu_wr  in  1  1 = store, 0 = load
cpu_size  in  2  0 = byte, 1 = half, 2 = word
cpu_addr  in  32  request address
cpu_wdata  in  32  store data
cpu_uncached  in  1  uncached attribute
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  store completed, or load data valid
cpu_rdata  out  32  load data
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream store/load select
mem_size  out  2  downstream size
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream store data
mem_uncached  out  1  downstream uncached attribute
mem_addr_ok  in  1  adapter accepted the request
mem_data_ok  in  1  adapter completed the request
mem_rdata  in  32  adapter load data
buf_empty  out  1  FIFO empty and downstream FSM in D_IDLE; used for sync/cache-op drain

Behaviour:
Reset (async assert; deassert sampled on clk):
- FIFO pointers and count = 0.
- Downstream FSM = D_IDLE.
- Write-ack register = 0; mem_req = 0; cpu_addr_ok = 0; cpu_data_ok = 0; buf_empty = 1.
- A downstream transaction in flight is abandoned; the adapter is reset by the same reset.

FIFO:
- Entry = {addr, size, wdata, uncached}, 67 bits.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- full = (count == DEPTH).

Store acceptance:
- cpu_addr_ok = cpu_req & cpu_wr & ~full & ~rd_busy, where rd_busy = FSM in D_RADDR or D_RDATA.
- A pop in the same cycle does not free a slot for a push; a full buffer refuses the push that cycle.
- Push happens on cpu_addr_ok.
- cpu_data_ok is a registered pulse exactly one cycle after acceptance.
- Back-to-back stores are accepted at 1 per cycle until full.

Load acceptance:
- cpu_addr_ok = cpu_req & ~cpu_wr & (count == 0) & FSM in D_IDLE.
- On accept, addr/size/uncached are latched and the FSM goes to D_RADDR.

Downstream FSM (drives mem_* from registers; mem_req is high only in the two *ADDR states):
- D_IDLE:
  - FIFO non-empty -> D_WADDR, presenting the head entry.
  - Otherwise, a load accepted -> D_RADDR.
  - Draining writes has priority over loads by construction, because loads require an empty FIFO.
- D_WADDR: mem_req = 1, mem_wr = 1, fields from the FIFO head. On mem_addr_ok -> D_WDATA.
- D_WDATA:
  - On mem_data_ok: pop the head.
  - If the FIFO is still non-empty after the pop -> D_WADDR; else -> D_IDLE.
  - Push and pop in the same cycle leave count unchanged.
- D_RADDR: mem_req = 1, mem_wr = 0, latched load fields. On mem_addr_ok -> D_RDATA.
- D_RDATA:
  - cpu_data_ok = mem_data_ok; cpu_rdata = mem_rdata (combinational pass-through).
  - On mem_data_ok -> D_IDLE.

Ordering and boundary cases:
- While a load is in flight, no new request of either kind is accepted.
- Store and load cpu_data_ok pulses can never coincide.
- A load issued while stores are pending is stalled (cpu_addr_ok = 0) until the last pop completes and the FSM reaches D_IDLE.
- A load can be accepted no earlier than the cycle after the FSM returns to D_IDLE.
- mem_addr_ok and mem_data_ok arriving in the same cycle while in a *ADDR state: only addr_ok is honoured; the adapter guarantees data_ok comes later.
- Minimum latencies:
  - Store: acceptance to data_ok = 1 cycle.
  - Load: acceptance to data_ok = 2 cycles + adapter latency.

Decomposition:
- Shared package cpu_if_pkg:
  - Size encodings SIZE_BYTE/HALF/WORD.
  - Downstream state enum {D_IDLE, D_WADDR, D_WDATA, D_RADDR, D_RDATA}.
  - wb_entry_t struct.
- One sub-module, wb_fifo: synchronous FIFO with parameter DEPTH, push/pop, and full/empty/count outputs, on the same async reset.
- The FSM and acceptance logic live in data_write_buffer.

Test Plan:
- Single store (addr 0xBFAF_8000, word, wdata 0x1234_5678, uncached=1) accepted at cycle t:
  - cpu_data_ok = 1 at t+1.
  - mem_req = 1 with the same fields at t+1.
  - buf_empty returns to 1 after mem_data_ok.
- Five back-to-back stores with DEPTH = 4 and mem_addr_ok held 0:
  - Four stores accepted.
  - Fifth store sees cpu_addr_ok = 0 until the first mem_data_ok pops an entry.
  - Drained addresses appear in issue order.
- Store to 0x100 followed immediately by a load from 0x100:
  - Load cpu_addr_ok stays 0 until the store's mem_data_ok.
  - Then the load issues and cpu_rdata equals mem_rdata 0xCAFE_0001 with a cpu_data_ok pulse.
- Load in flight with the adapter delaying data_ok 5 cycles, and a store request from the core during that window:
  - Store cpu_addr_ok = 0 until the load's cpu_data_ok.
  - Store is accepted the next cycle.
- Reset asserted asynchronously mid-D_WDATA with 3 entries queued:
  - mem_req = 0 and cpu_data_ok = 0 immediately.
  - buf_empty = 1.
  - After deassert, a new store drains normally.
- Pointer wrap: 10 stores issued with mixed byte/half/word sizes and a random adapter stall pattern:
  - Downstream sequence matches the input sequence exactly.
  - count never exceeds 4.
